write_back_stage: RTL and testbench
===================================

# write_back_stage

Registered, parametrised write-back stage for the MIPS pipeline. It sits between the MEM/WB boundary and the register file. It selects the write-back source (ALU result, memory load, link address) and performs sub-word load alignment and sign/zero extension. It suppresses writes to register 0, counts retired instructions for the debug unit, and latches a sticky halt when the halt instruction retires.

## Interface
Parameters:
- NB_DATA, 32, data width; must be a multiple of 16
- N_REGISTERS, 32, register-file depth
- NB_ADDR_REGISTERS, $clog2(N_REGISTERS), register index width
- NB_CONTROL_WB, 6, control bundle width; fixed layout below
- NB_RETIRE_CNT, 32, retired-instruction counter width

Ports:
- i_clk  in  1  clock; all state updates on its rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  MEM stage presents an instruction this cycle
- i_stall  in  1  debug-unit hold; no instruction accepted while high
- i_reg_data  in  NB_DATA  ALU result
- i_mem_data  in  NB_DATA  raw aligned memory word
- i_link_data  in  NB_DATA  PC+8 for JAL/JALR
- i_mem_byte_off  in  2  byte address bits [1:0] of the load
- i_reg_num  in  NB_ADDR_REGISTERS  destination register
- i_control_wb  in  NB_CONTROL_WB  [0] reg_write; [2:1] src (00 ALU, 01 MEM, 10 LINK, 11 ALU); [4:3] size (00 byte, 01 half, 1x word); [5] unsigned
- i_halt  in  1  instruction is HALT
- o_reg_w_data  out  NB_DATA  register-file write data
- o_reg_num  out  NB_ADDR_REGISTERS  register-file write index
- o_reg_w_en  out  1  register-file write strobe
- o_retired_cnt  out  NB_RETIRE_CNT  accepted-instruction count
- o_halted  out  1  sticky: HALT has retired

## Operation
- Accept condition: accept = i_valid & ~i_stall & ~o_halted.
- On accept, latch the outputs:
  - o_reg_w_data = extended/selected data
  - o_reg_num = i_reg_num
  - o_reg_w_en = reg_write & (i_reg_num != 0)
- When accept is low, o_reg_w_en is forced to 0. o_reg_w_data and o_reg_num hold their last values.
- Source mux: src 00/11 -> i_reg_data; 10 -> i_link_data; 01 -> load path.
- Load path (little-endian):
  - Byte: byte lane i_mem_byte_off (lane 0 = bits [7:0]).
  - Half: i_mem_byte_off[1] selects bits [15:0] or [31:16]; i_mem_byte_off[0] is ignored.
  - Word: passthrough.
  - The selected lane is sign-extended when [5]=0 and zero-extended when [5]=1, up to NB_DATA.
  - For NB_DATA>32, a word load is extended from bit 31 by the same rule.
- Size and unsigned bits are ignored for sources other than MEM.
- Counter: o_retired_cnt increments by 1 on each accept, including writes to register 0, instructions with reg_write=0, and HALT. It wraps modulo 2^NB_RETIRE_CNT.
- Halt handling:
  - An accepted instruction with i_halt=1 still performs its own write, if enabled, and is counted.
  - o_halted is set on the same edge and stays set until reset.
  - Once halted, all later inputs are ignored and no write or count occurs.
- The same-cycle write/read bypass is the register file's job, not this block's.

## Timing
- Latency: accept at edge N -> o_reg_w_en/data/num valid from N until edge N+1. The write strobe is a single-cycle pulse per accepted instruction.
- Back-to-back accepts produce consecutive pulses with no bubble.
- A stall asserted in the cycle an instruction is presented blocks that instruction. The upstream stage must hold it until the stall is released. No duplicate write on release.
- Reset values (asynchronous, immediate on i_reset low):
  - o_reg_w_data = 0, o_reg_num = 0, o_reg_w_en = 0
  - o_retired_cnt = 0, o_halted = 0
- Reset released mid-stream: the first accept happens on the first rising edge with i_reset high.
- i_valid with i_stall and HALT in the same cycle: stall wins; nothing is latched.

## Test plan
- Reset: drive i_reset=0 with random inputs -> all outputs 0. Release reset, present ALU write r5=0x1234_5678 with reg_write=1 -> next cycle o_reg_w_en=1, o_reg_num=5, data=0x1234_5678, o_retired_cnt=1.
- Loads: i_mem_data=0x80FF_7F81.
  - Byte offset 0, signed -> 0xFFFF_FF81.
  - Offset 1, unsigned -> 0x0000_007F.
  - Half offset 2, signed -> 0xFFFF_80FF.
  - Half offset 3, unsigned -> 0x0000_80FF.
  - Word -> 0x80FF_7F81.
- Register 0 and link: a write to r0 with reg_write=1 -> o_reg_w_en=0 and o_retired_cnt still increments. JAL to r31 with src=10 and i_link_data=0x0000_0048 -> r31 written with 0x48.
- Stall: three back-to-back writes with i_stall high for 2 cycles before the second -> exactly three strobes, no duplicates; counter reaches 3.
- Halt: HALT accepted at count 9, then 4 further valid writes -> o_halted=1 from the next cycle, o_retired_cnt=10, no further strobes. Async reset mid-cycle clears o_halted immediately.
- Wrap: NB_RETIRE_CNT=4, 17 accepts -> o_retired_cnt=1.

Source files
------------

// File: rtl/write_back_stage.sv
// Purpose: MIPS write-back stage. Selects the source, aligns and extends loads, drops r0 writes, counts retirements, latches halt.
// Latency: one cycle. An instruction accepted at edge N drives the register-file write from N until N+1.
// Backpressure: nothing is accepted while i_stall or o_halted is high; upstream holds the instruction until it is accepted.
module write_back_stage #(
   parameter int NB_DATA           = 32,
   parameter int N_REGISTERS       = 32,
   parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS),
   parameter int NB_CONTROL_WB     = 6,
   parameter int NB_RETIRE_CNT     = 32
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_valid,
   input  logic                         i_stall,
   input  logic [NB_DATA-1:0]           i_reg_data,
   input  logic [NB_DATA-1:0]           i_mem_data,
   input  logic [NB_DATA-1:0]           i_link_data,
   input  logic [1:0]                   i_mem_byte_off,
   input  logic [NB_ADDR_REGISTERS-1:0] i_reg_num,
   input  logic [NB_CONTROL_WB-1:0]     i_control_wb,
   input  logic                         i_halt,
   output logic [NB_DATA-1:0]           o_reg_w_data,
   output logic [NB_ADDR_REGISTERS-1:0] o_reg_num,
   output logic                         o_reg_w_en,
   output logic [NB_RETIRE_CNT-1:0]     o_retired_cnt,
   output logic                         o_halted
);

   // Control bundle fields.
   logic       reg_write;
   logic [1:0] src;
   logic [1:0] size;
   logic       is_unsigned;

   assign reg_write   = i_control_wb[0];
   assign src         = i_control_wb[2:1];
   assign size        = i_control_wb[4:3];
   assign is_unsigned = i_control_wb[5];

   logic                accept;
   logic [31:0]         mem_word;
   logic [7:0]          byte_lane;
   logic [15:0]         half_lane;
   logic [NB_DATA-1:0]  load_data;
   logic [NB_DATA-1:0]  wb_data;

   assign accept   = i_valid & ~i_stall & ~o_halted;
   // Sub-word loads only ever look at the low 32 bits of the memory word.
   assign mem_word = i_mem_data[31:0];

   // Load path: pick the addressed little-endian lane, then sign/zero extend to the full width.
   always_comb begin
      byte_lane = 8'h00;
      half_lane = i_mem_byte_off[1] ? mem_word[31:16] : mem_word[15:0];
      load_data = '0;
      case (i_mem_byte_off)
         2'd0:    byte_lane = mem_word[7:0];
         2'd1:    byte_lane = mem_word[15:8];
         2'd2:    byte_lane = mem_word[23:16];
         default: byte_lane = mem_word[31:24];
      endcase
      if (size[1]) begin
         load_data        = {NB_DATA{~is_unsigned & mem_word[31]}};
         load_data[31:0]  = mem_word;
      end else if (size[0]) begin
         load_data        = {NB_DATA{~is_unsigned & half_lane[15]}};
         load_data[15:0]  = half_lane;
      end else begin
         load_data        = {NB_DATA{~is_unsigned & byte_lane[7]}};
         load_data[7:0]   = byte_lane;
      end
   end

   // Source mux: ALU for 00/11, memory load for 01, link address for 10.
   always_comb begin
      wb_data = i_reg_data;
      case (src)
         2'b01:   wb_data = load_data;
         2'b10:   wb_data = i_link_data;
         default: wb_data = i_reg_data;
      endcase
   end

   // Output register: latch data/index on accept, pulse the strobe for exactly one cycle.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_reg_w_data <= '0;
         o_reg_num    <= '0;
         o_reg_w_en   <= 1'b0;
      end else if (accept) begin
         o_reg_w_data <= wb_data;
         o_reg_num    <= i_reg_num;
         o_reg_w_en   <= reg_write & (i_reg_num != '0);
      end else begin
         o_reg_w_en   <= 1'b0;
      end
   end

   // Retire counter and sticky halt; HALT itself is counted and halts on the same edge.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_retired_cnt <= '0;
         o_halted      <= 1'b0;
      end else if (accept) begin
         o_retired_cnt <= o_retired_cnt + NB_RETIRE_CNT'(1);
         if (i_halt) begin
            o_halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

   logic        i_clk;
   logic        i_reset;
   logic        i_valid;
   logic        i_stall;
   logic [31:0] i_reg_data;
   logic [31:0] i_mem_data;
   logic [31:0] i_link_data;
   logic [1:0]  i_mem_byte_off;
   logic [4:0]  i_reg_num;
   logic [5:0]  i_control_wb;
   logic        i_halt;
   logic [31:0] o_reg_w_data;
   logic [4:0]  o_reg_num;
   logic        o_reg_w_en;
   logic [31:0] o_retired_cnt;
   logic        o_halted;

   // Narrow-counter instance sharing the same stimulus, used to observe wrap-around.
   logic [31:0] n_reg_w_data;
   logic [4:0]  n_reg_num;
   logic        n_reg_w_en;
   logic [3:0]  n_retired_cnt;
   logic        n_halted;

   write_back_stage dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
      .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_link_data(i_link_data),
      .i_mem_byte_off(i_mem_byte_off), .i_reg_num(i_reg_num), .i_control_wb(i_control_wb),
      .i_halt(i_halt), .o_reg_w_data(o_reg_w_data), .o_reg_num(o_reg_num),
      .o_reg_w_en(o_reg_w_en), .o_retired_cnt(o_retired_cnt), .o_halted(o_halted)
   );

   write_back_stage #(.NB_RETIRE_CNT(4)) dut_wrap (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
      .i_reg_data(i_reg_data), .i_mem_data(i_mem_data), .i_link_data(i_link_data),
      .i_mem_byte_off(i_mem_byte_off), .i_reg_num(i_reg_num), .i_control_wb(i_control_wb),
      .i_halt(i_halt), .o_reg_w_data(n_reg_w_data), .o_reg_num(n_reg_num),
      .o_reg_w_en(n_reg_w_en), .o_retired_cnt(n_retired_cnt), .o_halted(n_halted)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;
   int strobes = 0;

   // Reference state
   logic [31:0] m_data;
   logic [4:0]  m_num;
   logic        m_en;
   int unsigned m_cnt;
   logic        m_halted;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected write-back value from the ISA rules: shift/mask/extend.
   function automatic logic [31:0] ref_value(input logic [5:0] ctrl, input logic [31:0] rd,
                                             input logic [31:0] md, input logic [31:0] ld,
                                             input logic [1:0] off);
      logic [31:0] v;
      int unsigned bits;
      if (ctrl[2:1] == 2'b10) return ld;
      if (ctrl[2:1] != 2'b01) return rd;
      if (ctrl[4]) return md;
      if (ctrl[3]) begin
         bits = 16;
         v = (md >> (off[1] * 16)) & 32'h0000_FFFF;
      end else begin
         bits = 8;
         v = (md >> (off * 8)) & 32'h0000_00FF;
      end
      if (!ctrl[5] && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
      return v;
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_data"}, o_reg_w_data, m_data);
      check({tag, "_num"},  o_reg_num, m_num);
      check({tag, "_en"},   o_reg_w_en, m_en);
      check({tag, "_cnt"},  o_retired_cnt, m_cnt);
      check({tag, "_halt"}, o_halted, m_halted);
      check({tag, "_cnt4"}, n_retired_cnt, m_cnt % 16);
   endtask

   task automatic present(input logic v, input logic s, input logic h, input logic [5:0] ctrl,
                          input logic [4:0] num, input logic [31:0] rd, input logic [31:0] md,
                          input logic [31:0] ld, input logic [1:0] off);
      i_valid = v; i_stall = s; i_halt = h; i_control_wb = ctrl; i_reg_num = num;
      i_reg_data = rd; i_mem_data = md; i_link_data = ld; i_mem_byte_off = off;
   endtask

   task automatic randomize_inputs();
      present($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
              6'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 2'($urandom));
   endtask

   // One clock: predict from the presented inputs, then compare just after the edge.
   task automatic cycle(input string tag);
      logic        acc;
      logic [31:0] nd;
      acc = i_valid && !i_stall && !m_halted;
      nd  = ref_value(i_control_wb, i_reg_data, i_mem_data, i_link_data, i_mem_byte_off);
      @(posedge i_clk);
      #1;
      if (acc) begin
         m_data = nd;
         m_num  = i_reg_num;
         m_en   = i_control_wb[0] && (i_reg_num != 0);
         m_cnt++;
         if (i_halt) m_halted = 1'b1;
      end else begin
         m_en = 1'b0;
      end
      if (o_reg_w_en === 1'b1) strobes++;
      check_all(tag);
   endtask

   task automatic model_reset();
      m_data = 0; m_num = 0; m_en = 0; m_cnt = 0; m_halted = 0;
   endtask

   // Called mid-cycle (just after an edge); reset must take effect without a clock.
   task automatic do_reset(input string tag);
      i_reset = 1'b0;
      #2;
      model_reset();
      check_all(tag);
      i_reset = 1'b1;
      strobes = 0;
   endtask

   initial begin
      i_reset = 1'b1;
      randomize_inputs();
      model_reset();
      #1;
      i_reset = 1'b0;
      #2;
      check_all("rst");
      i_reset = 1'b1;

      // First write after reset
      present(1, 0, 0, 6'b000001, 5'd5, 32'h1234_5678, 0, 0, 0);
      cycle("alu_r5");
      check("alu_r5_val", o_reg_w_data, 32'h1234_5678);
      check("alu_r5_cnt1", o_retired_cnt, 1);

      // Load alignment and extension
      present(1, 0, 0, 6'b000011, 5'd2, 0, 32'h80FF_7F81, 0, 2'd0);
      cycle("lb0");
      check("lb0_val", o_reg_w_data, 32'hFFFF_FF81);
      present(1, 0, 0, 6'b100011, 5'd2, 0, 32'h80FF_7F81, 0, 2'd1);
      cycle("lbu1");
      check("lbu1_val", o_reg_w_data, 32'h0000_007F);
      present(1, 0, 0, 6'b001011, 5'd2, 0, 32'h80FF_7F81, 0, 2'd2);
      cycle("lh2");
      check("lh2_val", o_reg_w_data, 32'hFFFF_80FF);
      present(1, 0, 0, 6'b101011, 5'd2, 0, 32'h80FF_7F81, 0, 2'd3);
      cycle("lhu3");
      check("lhu3_val", o_reg_w_data, 32'h0000_80FF);
      present(1, 0, 0, 6'b110011, 5'd2, 0, 32'h80FF_7F81, 0, 2'd1);
      cycle("lw");
      check("lw_val", o_reg_w_data, 32'h80FF_7F81);

      // r0 suppression and link
      present(1, 0, 0, 6'b000001, 5'd0, 32'hDEAD_BEEF, 0, 0, 0);
      cycle("r0");
      check("r0_en", o_reg_w_en, 0);
      check("r0_cnt", o_retired_cnt, 7);
      present(1, 0, 0, 6'b000101, 5'd31, 32'h1111_1111, 0, 32'h0000_0048, 0);
      cycle("jal");
      check("jal_val", o_reg_w_data, 32'h48);
      check("jal_num", o_reg_num, 31);
      check("jal_en", o_reg_w_en, 1);

      // Stall before the second of three writes
      @(posedge i_clk); #1;
      do_reset("rst2");
      present(1, 0, 0, 6'b000001, 5'd1, 32'hA, 0, 0, 0);
      cycle("st_w1");
      present(1, 1, 0, 6'b000001, 5'd2, 32'hB, 0, 0, 0);
      cycle("st_hold1");
      cycle("st_hold2");
      i_stall = 1'b0;
      cycle("st_w2");
      present(1, 0, 0, 6'b000001, 5'd3, 32'hC, 0, 0, 0);
      cycle("st_w3");
      present(0, 0, 0, 6'b000001, 5'd3, 32'hC, 0, 0, 0);
      cycle("st_idle");
      check("st_strobes", strobes, 3);
      check("st_cnt", o_retired_cnt, 3);

      // Halt at count 9, then four ignored writes
      do_reset("rst3");
      for (int i = 0; i < 9; i++) begin
         present(1, 0, 0, 6'b000001, 5'(i + 1), $urandom, 0, 0, 0);
         cycle("pre_halt");
      end
      present(1, 0, 1, 6'b000001, 5'd9, 32'h99, 0, 0, 0);
      cycle("halt");
      check("halt_flag", o_halted, 1);
      check("halt_en", o_reg_w_en, 1);
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         present(1, 0, 0, 6'b000001, 5'd4, $urandom, 0, 0, 0);
         cycle("post_halt");
      end
      check("post_halt_cnt", o_retired_cnt, 10);
      check("post_halt_strobes", strobes, 0);
      i_reset = 1'b0;
      #1;
      check("halt_async_clr", o_halted, 0);
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      do_reset("rst4");

      // Narrow counter wraps after 17 accepts
      for (int i = 0; i < 17; i++) begin
         present(1, 0, 0, 6'($urandom) & 6'b111110, 5'($urandom), $urandom, $urandom, $urandom, 0);
         cycle("wrap");
      end
      check("wrap_cnt4", n_retired_cnt, 1);
      check("wrap_cnt32", o_retired_cnt, 17);

      // Random traffic, occasionally resetting after a halt
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         cycle("rnd");
         if (m_halted && $urandom_range(0, 7) == 0) do_reset("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
